ecc_inject_sequencer: RTL

//  Self-test controller for the SEC-DED path: encoder -> error toggler -> decoder.
//  On start it walks the toggler error select through a no-error step (4'hF), then indices 0..12.

---
 rtl/ecc_inject_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ecc_inject_sequencer.sv
// ecc_inject_sequencer
//   Self-test controller for a SEC-DED path (encoder -> error toggler -> decoder).
//   A run sweeps the toggler error select through 4'hF (no injection) and then
//   indices 0..12, driving the test byte into the encoder and checking the
//   decoder response DEC_LAT cycles later. PASSES sweeps make one run.
//
//   Optional feature macro: SEQ_LFSR_EN
//     defined   : the test byte is an 8-bit Fibonacci LFSR seeded from
//                 data_pattern_i (0 -> 8'hA5), advanced at the start of every
//                 pass after the first.
//     undefined : the byte latched at start is used for every pass.
//
// Ports
//   clk_i, reset_i        clock (rising edge), async active-high reset
//   start_i, abort_i      run request (IDLE only), synchronous abort
//   data_pattern_i        test byte / LFSR seed, latched on accepted start
//   dec_data_i/_single_i/_double_i   decoder outputs under test
//   err_sel_o, enc_data_o toggler select (4'hF = none) and encoder byte
//   busy_o, done_o, pass_o           run status
//   fail_count_o          failing steps (saturating), first_fail_idx_o (4'hE = none)
module ecc_inject_sequencer #(
    parameter int DEC_LAT = 1,
    parameter int PASSES  = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] data_pattern_i,
    input  logic [7:0] dec_data_i,
    input  logic       dec_single_i,
    input  logic       dec_double_i,
    output logic [3:0] err_sel_o,
    output logic [7:0] enc_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] fail_count_o,
    output logic [3:0] first_fail_idx_o
);

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_e;

    localparam logic [3:0] NO_ERR    = 4'hF;
    localparam logic [3:0] NO_FAIL   = 4'hE;
    localparam logic [3:0] LAST_IDX  = 4'd12;
    localparam logic [3:0] LAT       = 4'(DEC_LAT);
    localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

    state_e     state_q;
    logic [3:0] err_sel_q, first_fail_q, wait_q;
    logic [7:0] enc_data_q, fail_count_q, pass_cnt_q;
    logic       busy_q, done_q, pass_q;

    logic       sample_d, step_fail_d;
    logic [3:0] next_sel_d;
    logic [7:0] fail_count_d, seed_d, next_pat_d;

    // Sample edge of the current step: the decoder has had DEC_LAT cycles.
    assign sample_d   = (wait_q == LAT);
    // Only the no-injection step expects a clean decode; every index must be
    // reported as a corrected single-bit error with the original byte.
    assign step_fail_d = (dec_data_i != enc_data_q)
                       || (dec_single_i != (err_sel_q != NO_ERR))
                       || dec_double_i;
    assign fail_count_d = (step_fail_d && fail_count_q != 8'hFF)
                        ? fail_count_q + 8'd1 : fail_count_q;
    assign next_sel_d = (err_sel_q == NO_ERR) ? 4'd0 : err_sel_q + 4'd1;

`ifdef SEQ_LFSR_EN
    // An all-zero seed would lock the LFSR, so substitute a fixed nonzero one.
    assign seed_d     = (data_pattern_i == 8'h00) ? 8'hA5 : data_pattern_i;
    assign next_pat_d = {enc_data_q[6:0],
                         enc_data_q[7] ^ enc_data_q[5] ^ enc_data_q[4] ^ enc_data_q[3]};
`else
    assign seed_d     = data_pattern_i;
    assign next_pat_d = enc_data_q;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            err_sel_q    <= NO_ERR;
            enc_data_q   <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 8'h00;
            first_fail_q <= NO_FAIL;
            wait_q       <= 4'd0;
            pass_cnt_q   <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q      <= STEP;
                        err_sel_q    <= NO_ERR;
                        enc_data_q   <= seed_d;
                        wait_q       <= 4'd0;
                        pass_cnt_q   <= 8'h00;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        fail_count_q <= 8'h00;
                        first_fail_q <= NO_FAIL;
                    end
                end
                STEP: begin
                    if (abort_i) begin
                        // Abort beats the sample on the same edge; partial
                        // counts are left visible.
                        state_q    <= IDLE;
                        err_sel_q  <= NO_ERR;
                        busy_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        wait_q     <= 4'd0;
                        pass_cnt_q <= 8'h00;
                    end else if (!sample_d) begin
                        wait_q <= wait_q + 4'd1;
                    end else begin
                        wait_q       <= 4'd0;
                        fail_count_q <= fail_count_d;
                        if (step_fail_d && fail_count_q == 8'h00)
                            first_fail_q <= err_sel_q;
                        if (err_sel_q != LAST_IDX) begin
                            err_sel_q <= next_sel_d;
                        end else begin
                            err_sel_q <= NO_ERR;
                            if (pass_cnt_q == LAST_PASS) begin
                                state_q    <= DONE;
                                done_q     <= 1'b1;
                                busy_q     <= 1'b0;
                                pass_q     <= (fail_count_d == 8'h00);
                                pass_cnt_q <= 8'h00;
                            end else begin
                                pass_cnt_q <= pass_cnt_q + 8'd1;
                                enc_data_q <= next_pat_d;
                            end
                        end
                    end
                end
                // One-cycle status slot; start is not accepted here.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign err_sel_o        = err_sel_q;
    assign enc_data_o       = enc_data_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign fail_count_o     = fail_count_q;
    assign first_fail_idx_o = first_fail_q;

endmodule
